// File: rtl/draw_engine_if.sv
// Bundle of the draw engine's request/completion handshakes, square read port and pixel bus.
// The engine is the slave side; the game controller and VGA writer sit on the master side.
interface draw_engine_if;
   logic       draw_squares;
   logic       draw_catcher;
   logic       draw_score;
   logic       draw_end;
   logic [1:0] sq_index;
   logic [7:0] sq_x;
   logic [6:0] sq_y;
   logic       sq_active;
   logic [7:0] catcher_x;
   logic [3:0] score;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot_en;
   logic       finish_drawing_squares;
   logic       finish_drawing_catcher;
   logic       finish_drawing_score;
   logic       finish_drawing_end;

   modport slave (
      input  draw_squares, draw_catcher, draw_score, draw_end,
      input  sq_x, sq_y, sq_active, catcher_x, score,
      output sq_index, x, y, colour, plot_en,
      output finish_drawing_squares, finish_drawing_catcher,
      output finish_drawing_score, finish_drawing_end
   );

   modport master (
      output draw_squares, draw_catcher, draw_score, draw_end,
      output sq_x, sq_y, sq_active, catcher_x, score,
      input  sq_index, x, y, colour, plot_en,
      input  finish_drawing_squares, finish_drawing_catcher,
      input  finish_drawing_score, finish_drawing_end
   );
endinterface

// File: rtl/draw_engine.sv
// Pixel generator for squares, catcher, score bar and end screen; one pixel per cycle.
// Optional macro DRAW_BORDER_EN paints a white frame around the end screen.
module draw_engine (
   input  logic         clock,
   input  logic         reset,
   draw_engine_if.slave bus
);
   typedef enum logic [2:0] {IDLE, SQUARES, CATCHER, SCORE, END, DONE} state_t;

   localparam logic [14:0] SQUARES_PIXELS = 15'd64;
   localparam logic [14:0] CATCHER_PIXELS = 15'd64;
   localparam logic [14:0] SCORE_PIXELS   = 15'd128;
   localparam logic [14:0] END_PIXELS     = 15'd19200;

   state_t      state, state_next;
   state_t      render, render_next;
   state_t      accept_sel, pix_sel;
   logic [14:0] counter, counter_next;
   logic [14:0] pixel_total;
   logic [6:0]  pix_idx;
   logic [7:0]  x_reg, x_next, pix_x;
   logic [6:0]  y_reg, y_next, pix_y;
   logic [2:0]  colour_reg, colour_next, pix_colour;
   logic        plot_reg, plot_next;
   logic        request_held;
   logic [7:0]  sq_ox, catcher_ox;
   logic [6:0]  sq_oy;

   // Request arbitration when idle: end screen wins, then squares, catcher, score.
   always_comb begin
      accept_sel = IDLE;
      if (bus.draw_end)
         accept_sel = END;
      else if (bus.draw_squares)
         accept_sel = SQUARES;
      else if (bus.draw_catcher)
         accept_sel = CATCHER;
      else if (bus.draw_score)
         accept_sel = SCORE;
   end

   always_comb begin
      request_held = 1'b0;
      pixel_total  = '0;
      case (state)
         SQUARES: begin request_held = bus.draw_squares; pixel_total = SQUARES_PIXELS; end
         CATCHER: begin request_held = bus.draw_catcher; pixel_total = CATCHER_PIXELS; end
         SCORE:   begin request_held = bus.draw_score;   pixel_total = SCORE_PIXELS;   end
         END:     begin request_held = bus.draw_end;     pixel_total = END_PIXELS;     end
         default: begin request_held = 1'b0;             pixel_total = '0;             end
      endcase
   end

   // While idle the pixel path previews pixel 0 of whichever render would be accepted.
   assign pix_sel = (state == IDLE) ? accept_sel : state;
   assign pix_idx = (state == IDLE) ? 7'd0 : counter[6:0];

   assign sq_ox      = (bus.sq_x > 8'd156)      ? 8'd156 : bus.sq_x;
   assign sq_oy      = (bus.sq_y > 7'd116)      ? 7'd116 : bus.sq_y;
   assign catcher_ox = (bus.catcher_x > 8'd144) ? 8'd144 : bus.catcher_x;

   assign bus.sq_index = counter[5:4];

   always_comb begin
      pix_x      = '0;
      pix_y      = '0;
      pix_colour = '0;
      case (pix_sel)
         SQUARES: begin
            pix_x      = sq_ox + {6'd0, pix_idx[1:0]};
            pix_y      = sq_oy + {5'd0, pix_idx[3:2]};
            pix_colour = bus.sq_active ? 3'b011 : 3'b000;
         end
         CATCHER: begin
            pix_x      = catcher_ox + {4'd0, pix_idx[3:0]};
            pix_y      = 7'd112 + {5'd0, pix_idx[5:4]};
            pix_colour = 3'b110;
         end
         SCORE: begin
            pix_x      = {2'd0, pix_idx[6:3], pix_idx[1:0]};
            pix_y      = {6'd0, pix_idx[2]};
            pix_colour = (pix_idx[6:3] < bus.score) ? 3'b010 : 3'b000;
         end
         END: begin
            // The raster steps from the previous pixel, so no divide is needed.
            if (state == IDLE) begin
               pix_x = 8'd0;
               pix_y = 7'd0;
            end else if (x_reg == 8'd159) begin
               pix_x = 8'd0;
               pix_y = y_reg + 7'd1;
            end else begin
               pix_x = x_reg + 8'd1;
               pix_y = y_reg;
            end
`ifdef DRAW_BORDER_EN
            pix_colour = (pix_x == 8'd0 || pix_x == 8'd159 || pix_y == 7'd0 || pix_y == 7'd119)
                         ? 3'b111 : 3'b100;
`else
            pix_colour = 3'b100;
`endif
         end
         default: begin
            pix_x      = '0;
            pix_y      = '0;
            pix_colour = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         render     <= IDLE;
         counter    <= '0;
         x_reg      <= '0;
         y_reg      <= '0;
         colour_reg <= '0;
         plot_reg   <= 1'b0;
      end else begin
         state      <= state_next;
         render     <= render_next;
         counter    <= counter_next;
         x_reg      <= x_next;
         y_reg      <= y_next;
         colour_reg <= colour_next;
         plot_reg   <= plot_next;
      end
   end

   // Counter holds the number of pixels already emitted for the current render.
   always_comb begin
      state_next   = state;
      render_next  = render;
      counter_next = counter;
      x_next       = x_reg;
      y_next       = y_reg;
      colour_next  = colour_reg;
      plot_next    = 1'b0;
      case (state)
         IDLE: begin
            counter_next = '0;
            if (accept_sel != IDLE) begin
               state_next   = accept_sel;
               render_next  = accept_sel;
               x_next       = pix_x;
               y_next       = pix_y;
               colour_next  = pix_colour;
               plot_next    = 1'b1;
               counter_next = 15'd1;
            end
         end
         SQUARES, CATCHER, SCORE, END: begin
            if (!request_held) begin
               state_next   = IDLE;
               render_next  = IDLE;
               counter_next = '0;
            end else if (counter == pixel_total) begin
               state_next = DONE;
            end else begin
               x_next       = pix_x;
               y_next       = pix_y;
               colour_next  = pix_colour;
               plot_next    = 1'b1;
               counter_next = counter + 15'd1;
            end
         end
         DONE: begin
            state_next   = IDLE;
            counter_next = '0;
         end
         default: begin
            state_next   = IDLE;
            render_next  = IDLE;
            counter_next = '0;
         end
      endcase
   end

   assign bus.x       = x_reg;
   assign bus.y       = y_reg;
   assign bus.colour  = colour_reg;
   assign bus.plot_en = plot_reg;

   assign bus.finish_drawing_squares = (state == DONE) && (render == SQUARES);
   assign bus.finish_drawing_catcher = (state == DONE) && (render == CATCHER);
   assign bus.finish_drawing_score   = (state == DONE) && (render == SCORE);
   assign bus.finish_drawing_end     = (state == DONE) && (render == END);
endmodule

// File: tb/tb_draw_engine.sv
// Self-checking bench for draw_engine: table of whole renders plus hand-written abort,
// priority and reset sequences. Expected end-screen colours follow DRAW_BORDER_EN.
module tb_draw_engine;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   passes = 0;

   always #5 clock = ~clock;

   draw_engine_if bus ();
   draw_engine dut (.clock(clock), .reset(reset), .bus(bus));

   logic [7:0] tb_sqx [4];
   logic [6:0] tb_sqy [4];
   logic       tb_sqa [4];

   assign bus.sq_x      = tb_sqx[bus.sq_index];
   assign bus.sq_y      = tb_sqy[bus.sq_index];
   assign bus.sq_active = tb_sqa[bus.sq_index];

`ifdef DRAW_BORDER_EN
   localparam int CORNER   = 7;
   localparam int END_MAIN = 18644;
`else
   localparam int CORNER   = 4;
   localparam int END_MAIN = 19200;
`endif

   // code: 0 squares, 1 catcher, 2 score, 3 end
   typedef struct {
      int          code;
      logic [31:0] sqx;
      logic [27:0] sqy;
      logic [3:0]  sqa;
      int cx; int sc; int n; int col_a; int cnt_a;
      int xmin; int xmax; int ymin; int ymax;
      int bxl; int bxh; int byl; int byh; int bcnt; int bcol;
      int chk_last; int lx; int ly; int fin;
   } vec_t;

   vec_t vecs [9];

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected)
         passes++;
      else
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   function automatic logic [3:0] finVec();
      return {bus.finish_drawing_end, bus.finish_drawing_score,
              bus.finish_drawing_catcher, bus.finish_drawing_squares};
   endfunction

   task automatic setRequest(input int code, input logic val);
      case (code)
         0: bus.draw_squares = val;
         1: bus.draw_catcher = val;
         2: bus.draw_score   = val;
         default: bus.draw_end = val;
      endcase
   endtask

   task automatic applyStimulus(input int vi, input vec_t v);
      int npix = 0; int cnt_a = 0; int bcnt = 0; int bbad = 0; int order_bad = 0;
      int fin_cycle = -1; int xmin = 999; int xmax = -1; int ymin = 999; int ymax = -1;
      int lx = -1; int ly = -1; int px; int py; int pc; int s; int ex; int ey; int ec;
      logic [3:0] fin_seen = 4'd0;
      for (int k = 0; k < 4; k++) begin
         tb_sqx[k] = v.sqx[8*k +: 8];
         tb_sqy[k] = v.sqy[7*k +: 7];
         tb_sqa[k] = v.sqa[k];
      end
      bus.catcher_x = 8'(v.cx);
      bus.score     = 4'(v.sc);
      setRequest(v.code, 1'b1);
      @(posedge clock); #1;
      for (int e = 0; e < v.n + 20; e++) begin
         if (bus.plot_en) begin
            px = int'(bus.x); py = int'(bus.y); pc = int'(bus.colour);
            if (pc == v.col_a) cnt_a++;
            if (px < xmin) xmin = px;
            if (px > xmax) xmax = px;
            if (py < ymin) ymin = py;
            if (py > ymax) ymax = py;
            if (px >= v.bxl && px <= v.bxh && py >= v.byl && py <= v.byh) begin
               bcnt++;
               if (pc != v.bcol) bbad++;
            end
            ex = 0; ey = 0; ec = 0;
            if (v.code == 0) begin
               s  = npix / 16;
               ex = ((tb_sqx[s] > 156) ? 156 : int'(tb_sqx[s])) + (npix % 4);
               ey = ((tb_sqy[s] > 116) ? 116 : int'(tb_sqy[s])) + ((npix / 4) % 4);
               ec = tb_sqa[s] ? 3 : 0;
            end else if (v.code == 3) begin
               ex = npix % 160;
               ey = npix / 160;
               ec = (ex == 0 || ex == 159 || ey == 0 || ey == 119) ? CORNER : 4;
            end
            if ((v.code == 0 || v.code == 3) && (ex != px || ey != py || ec != pc))
               order_bad++;
            lx = px; ly = py;
            npix++;
         end
         if (finVec() != 4'd0) begin
            fin_seen  = finVec();
            fin_cycle = e + 1;
            break;
         end
         @(posedge clock); #1;
      end
      setRequest(v.code, 1'b0);
      checkOutput($sformatf("v%0d_npix", vi), npix, v.n);
      checkOutput($sformatf("v%0d_colour_count", vi), cnt_a, v.cnt_a);
      checkOutput($sformatf("v%0d_xmin", vi), xmin, v.xmin);
      checkOutput($sformatf("v%0d_xmax", vi), xmax, v.xmax);
      checkOutput($sformatf("v%0d_ymin", vi), ymin, v.ymin);
      checkOutput($sformatf("v%0d_ymax", vi), ymax, v.ymax);
      checkOutput($sformatf("v%0d_box_count", vi), bcnt, v.bcnt);
      checkOutput($sformatf("v%0d_box_colour_bad", vi), bbad, 0);
      checkOutput($sformatf("v%0d_finish_cycle", vi), fin_cycle, v.fin);
      checkOutput($sformatf("v%0d_finish_onehot", vi), int'(fin_seen), 1 << v.code);
      if (v.code == 0 || v.code == 3)
         checkOutput($sformatf("v%0d_order_bad", vi), order_bad, 0);
      if (v.chk_last != 0) begin
         checkOutput($sformatf("v%0d_last_x", vi), lx, v.lx);
         checkOutput($sformatf("v%0d_last_y", vi), ly, v.ly);
      end
      @(posedge clock); #1;
      checkOutput($sformatf("v%0d_plot_after_done", vi), int'(bus.plot_en), 0);
      checkOutput($sformatf("v%0d_finish_after_done", vi), int'(finVec()), 0);
   endtask

   initial begin
      int fin_cycle;
      logic [3:0] fin_acc;
      logic plot_acc;

      bus.draw_squares = 1'b0; bus.draw_catcher = 1'b0;
      bus.draw_score   = 1'b0; bus.draw_end     = 1'b0;
      bus.catcher_x    = 8'd0; bus.score        = 4'd0;
      for (int k = 0; k < 4; k++) begin
         tb_sqx[k] = 8'd0; tb_sqy[k] = 7'd0; tb_sqa[k] = 1'b0;
      end

      // code, sqx{3..0}, sqy{3..0}, sqa, cx, sc, n, col_a, cnt_a, xmin, xmax, ymin, ymax,
      // box xl, xh, yl, yh, box count, box colour, chk_last, last x, last y, finish cycle
      vecs[0] = '{0, {8'd50, 8'd0, 8'd157, 8'd10}, {7'd60, 7'd0, 7'd117, 7'd20}, 4'b1101,
                  0, 0, 64, 3, 48, 0, 159, 0, 119, 156, 159, 116, 119, 16, 0, 1, 53, 63, 65};
      vecs[1] = '{0, {4{8'd255}}, {4{7'd127}}, 4'b1111,
                  0, 0, 64, 3, 64, 156, 159, 116, 119, 156, 159, 116, 119, 64, 3, 1, 159, 119, 65};
      vecs[2] = '{1, 32'd0, 28'd0, 4'd0,
                  150, 0, 64, 6, 64, 144, 159, 112, 115, 144, 159, 112, 115, 64, 6, 0, 0, 0, 65};
      vecs[3] = '{1, 32'd0, 28'd0, 4'd0,
                  0, 0, 64, 6, 64, 0, 15, 112, 115, 0, 15, 112, 115, 64, 6, 0, 0, 0, 65};
      vecs[4] = '{1, 32'd0, 28'd0, 4'd0,
                  145, 0, 64, 6, 64, 144, 159, 112, 115, 144, 159, 112, 115, 64, 6, 0, 0, 0, 65};
      vecs[5] = '{2, 32'd0, 28'd0, 4'd0,
                  0, 5, 128, 2, 40, 0, 63, 0, 1, 0, 19, 0, 1, 40, 2, 0, 0, 0, 129};
      vecs[6] = '{2, 32'd0, 28'd0, 4'd0,
                  0, 0, 128, 2, 0, 0, 63, 0, 1, 0, 63, 0, 1, 128, 0, 0, 0, 0, 129};
      vecs[7] = '{2, 32'd0, 28'd0, 4'd0,
                  0, 15, 128, 2, 120, 0, 63, 0, 1, 60, 63, 0, 1, 8, 0, 0, 0, 0, 129};
      vecs[8] = '{3, 32'd0, 28'd0, 4'd0,
                  0, 0, 19200, 4, END_MAIN, 0, 159, 0, 119, 159, 159, 119, 119, 1, CORNER,
                  1, 159, 119, 19201};

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      checkOutput("reset_plot_en", int'(bus.plot_en), 0);
      checkOutput("reset_x", int'(bus.x), 0);
      checkOutput("reset_y", int'(bus.y), 0);
      checkOutput("reset_colour", int'(bus.colour), 0);
      checkOutput("reset_sq_index", int'(bus.sq_index), 0);
      checkOutput("reset_finish", int'(finVec()), 0);
      reset = 1'b1;

      for (int i = 0; i < 9; i++)
         applyStimulus(i, vecs[i]);

      // End screen outranks score; dropping both aborts without a finish
      bus.draw_score = 1'b1; bus.draw_end = 1'b1;
      @(posedge clock); #1;
      checkOutput("prio_end_plot", int'(bus.plot_en), 1);
      checkOutput("prio_end_colour", int'(bus.colour), CORNER);
      checkOutput("prio_end_xy", int'(bus.x) + int'(bus.y), 0);
      bus.draw_score = 1'b0; bus.draw_end = 1'b0;
      fin_acc = 4'd0;
      repeat (3) begin
         @(posedge clock); #1;
         fin_acc = fin_acc | finVec();
      end
      checkOutput("prio_abort_plot", int'(bus.plot_en), 0);
      checkOutput("prio_abort_finish", int'(fin_acc), 0);

      // Squares and catcher together: squares first, abort at pixel 10, then catcher
      tb_sqx[0] = 8'd10; tb_sqy[0] = 7'd20; tb_sqa[0] = 1'b1;
      bus.catcher_x = 8'd150;
      bus.draw_squares = 1'b1; bus.draw_catcher = 1'b1;
      @(posedge clock); #1;
      checkOutput("both_first_x", int'(bus.x), 10);
      checkOutput("both_first_y", int'(bus.y), 20);
      checkOutput("both_first_colour", int'(bus.colour), 3);
      repeat (10) @(posedge clock);
      #1;
      checkOutput("both_px10_x", int'(bus.x), 12);
      checkOutput("both_px10_y", int'(bus.y), 22);
      checkOutput("both_px10_colour", int'(bus.colour), 3);
      bus.draw_squares = 1'b0;
      @(posedge clock); #1;
      checkOutput("drop_plot_en", int'(bus.plot_en), 0);
      checkOutput("drop_finish", int'(finVec()), 0);
      @(posedge clock); #1;
      checkOutput("catcher_after_x", int'(bus.x), 144);
      checkOutput("catcher_after_y", int'(bus.y), 112);
      checkOutput("catcher_after_colour", int'(bus.colour), 6);
      fin_cycle = -1;
      fin_acc = 4'd0;
      for (int e = 1; e < 90; e++) begin
         @(posedge clock); #1;
         if (finVec() != 4'd0) begin
            fin_acc = finVec();
            fin_cycle = e + 1;
            break;
         end
      end
      checkOutput("catcher_after_finish_cycle", fin_cycle, 65);
      checkOutput("catcher_after_finish_onehot", int'(fin_acc), 2);
      bus.draw_catcher = 1'b0;
      repeat (2) @(posedge clock);
      #1;

      // Reset in the middle of the end screen
      bus.draw_end = 1'b1;
      @(posedge clock);
      repeat (500) @(posedge clock);
      #1;
      checkOutput("end500_x", int'(bus.x), 20);
      checkOutput("end500_y", int'(bus.y), 3);
      reset = 1'b0;
      @(posedge clock); #1;
      checkOutput("rst_mid_plot_en", int'(bus.plot_en), 0);
      checkOutput("rst_mid_finish", int'(finVec()), 0);
      checkOutput("rst_mid_x", int'(bus.x), 0);
      checkOutput("rst_mid_y", int'(bus.y), 0);
      checkOutput("rst_mid_colour", int'(bus.colour), 0);
      bus.draw_end = 1'b0;
      reset = 1'b1;
      fin_acc = 4'd0;
      plot_acc = 1'b0;
      repeat (5) begin
         @(posedge clock); #1;
         fin_acc = fin_acc | finVec();
         plot_acc = plot_acc | bus.plot_en;
      end
      checkOutput("rst_mid_quiet_finish", int'(fin_acc), 0);
      checkOutput("rst_mid_quiet_plot", int'(plot_acc), 0);

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/draw_engine.md
DRAW_ENGINE -- requirements
Module: draw_engine

Interface
REQ-001 clock  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-low; low on a rising edge forces reset state.
REQ-003 draw_squares  input  1  level request: render falling squares; held high until finish_drawing_squares seen.
REQ-004 draw_catcher  input  1  level request: render catcher.
REQ-005 draw_score  input  1  level request: render score bar.
REQ-006 draw_end  input  1  level request: render end screen.
REQ-007 sq_index  output  2  index of square currently read; sq_x/sq_y/sq_active refer to it same cycle (combinational source).
REQ-008 sq_x  input  8  top-left x of square sq_index.
REQ-009 sq_y  input  7  top-left y of square sq_index.
REQ-010 sq_active  input  1  square sq_index is live; inactive squares drawn black.
REQ-011 catcher_x  input  8  catcher left x.
REQ-012 score  input  4  current score, 0..15.
REQ-013 x  output  8  pixel x, 0..159, registered.
REQ-014 y  output  7  pixel y, 0..119, registered.
REQ-015 colour  output  3  pixel RGB, registered.
REQ-016 plot_en  output  1  x/y/colour valid this cycle; VGA write enable.
REQ-017 finish_drawing_squares / _catcher / _score / _end  output  1 each  one-cycle completion pulses.

Function
REQ-018 States: IDLE, SQUARES, CATCHER, SCORE, END, DONE.
REQ-019 IDLE accepts on a rising edge with any request high; priority end > squares > catcher > score.
REQ-020 On accept, pixel 0 is loaded into x/y/colour with plot_en=1; one new pixel every cycle thereafter, no gaps.
REQ-021 SQUARES: 4 squares x 4x4 pixels = 64 cycles; sq_index = counter[5:4]; row-major inside each square; colour 3'b011 if sq_active else 3'b000.
REQ-022 Square origin clamps: sq_x > 156 treated as 156, sq_y > 116 treated as 116.
REQ-023 CATCHER: 16x4 block at (catcher_x, 112), 64 cycles, colour 3'b110; catcher_x > 144 treated as 144.
REQ-024 SCORE: 16 cells of 4x2 pixels along y=0..1, x=0..63, 128 cycles; cell i colour 3'b010 if i < score else 3'b000.
REQ-025 END: full 160x120 raster, row-major from (0,0), 19200 cycles, colour 3'b100; x wraps 159->0 with y+1.
REQ-026 After the last pixel, state DONE for one cycle: plot_en=0, matching finish_* =1; then IDLE.
REQ-027 Exactly one finish_* high at a time; never asserted outside DONE.
REQ-028 Active request dropped mid-render: next cycle IDLE, plot_en=0, no finish pulse.
REQ-029 Other requests raised mid-render are ignored until IDLE.
REQ-030 Latency: accept edge k -> pixels at cycles k+1..k+N -> finish at k+N+1.

Reset
REQ-031 reset low: state IDLE, counter 0, x=0, y=0, colour=0, plot_en=0, sq_index=0, all finish_*=0, regardless of state; no finish for aborted render.

Configuration
REQ-032 DRAW_BORDER_EN defined: END raster pixels with x=0, x=159, y=0 or y=119 use colour 3'b111; interior 3'b100.
REQ-033 DRAW_BORDER_EN undefined: END raster uniformly 3'b100; all other behaviour identical.

Verification
REQ-034 Reset mid-END at pixel 500 -> next cycle plot_en=0, state IDLE, no finish_drawing_end.
REQ-035 draw_squares, squares 0..3 at (10,20),(157,117),(0,0),(50,60), sq_active=1,0,1,1 -> 64 pixels; square 1 drawn at (156,116) colour 000; finish_drawing_squares at cycle 65.
REQ-036 draw_catcher, catcher_x=150 -> 64 pixels x 144..159, y 112..115, colour 110; finish at cycle 65.
REQ-037 draw_score, score=5 -> 40 pixels colour 010 (x 0..19), 88 pixels 000; finish at cycle 129.
REQ-038 draw_end, macro on and off -> 19200 pixels, last (159,119); corner colour 111 with macro, 100 without; finish at cycle 19201.
REQ-039 draw_squares and draw_catcher high same edge -> squares rendered first; draw_squares dropped at pixel 10 -> IDLE, no finish, then catcher accepted.
